// File: rtl/seven_seg_pkg.sv
// Shared 7-segment glyph table and BCD-to-segment decode for display blocks.
// Latency: none, constants and a pure function only.
// Backpressure: not applicable.
package seven_seg_pkg;

  // Segment patterns in {g,f,e,d,c,b,a} order, active-high (1 = segment lit).
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Codes 10-15 are not BCD; they show a dash so a corrupted counter is visible
  // on the display instead of being silently rendered as some digit.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Decodes one BCD digit to active-high segments, with a force-blank input.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Blank wins over the glyph; invalid codes fall through to the dash pattern.
  always_comb begin
    seg = SEG_OFF;
    if (!blank) begin
      seg = bcd_to_seg(digit);
    end
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed 7-segment scanner: per-frame input snapshot, leading-zero and ghost blanking.
// Latency: seg/dp/an are registered, one cycle behind (digit_idx, timer, snapshot).
// Backpressure: none; free-running scan, inputs sampled once per frame.
module bcd_display_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       bcd,
  input  logic [NUM_DIGITS-1:0]         dp_en,
  input  logic                          blank_lz,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int TMR_W = $clog2(SCAN_DIV);

  localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(SCAN_DIV - 1);
  localparam logic [TMR_W-1:0] BLANK_LIM = TMR_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

  // Output polarity: XOR with this turns the active-high internal form into pad levels.
  localparam logic POL = (ACTIVE_LOW != 0);

  // Slot timer and frame boundary detection.
  logic [TMR_W-1:0] timer;
  logic             slot_end;
  logic             frame_end;

  // Frame snapshot of the inputs; the display never tears within a frame.
  logic [NUM_DIGITS-1:0][3:0] bcd_s;
  logic [NUM_DIGITS-1:0]      dp_en_s;
  logic                       blank_lz_s;
  logic                       snap_first;

  // Per-digit leading-zero blank mask derived from the snapshot.
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_run;

  // Next-cycle output values in active-high form.
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic [6:0]            seg_hi;
  logic                  dp_hi;
  logic [NUM_DIGITS-1:0] an_hi;

  assign slot_end  = (timer == TMR_MAX);
  assign frame_end = slot_end && (digit_idx == IDX_MAX);

  // Slot timer: counts 0..SCAN_DIV-1 and wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (slot_end) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Digit index advances on every slot wrap, last digit back to digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_idx <= '0;
    end else if (slot_end) begin
      if (digit_idx == IDX_MAX) begin
        digit_idx <= '0;
      end else begin
        digit_idx <= digit_idx + 1'b1;
      end
    end
  end

  // Snapshot on the edge entering digit 0 of a new frame, plus the first edge
  // after reset so the first frame does not show the cleared registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_s      <= '0;
      dp_en_s    <= '0;
      blank_lz_s <= 1'b0;
      snap_first <= 1'b1;
    end else begin
      snap_first <= 1'b0;
      if (snap_first || frame_end) begin
        bcd_s      <= bcd;
        dp_en_s    <= dp_en;
        blank_lz_s <= blank_lz;
      end
    end
  end

  // Leading-zero mask: walk from the top digit down while digits are zero.
  // An invalid code is non-zero and ends the run; digit 0 is never blanked.
  always_comb begin
    lz_mask  = '0;
    zero_run = blank_lz_s;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run   = zero_run && (bcd_s[i] == 4'd0);
      lz_mask[i] = zero_run;
    end
  end

  assign cur_digit = bcd_s[digit_idx];
  assign cur_blank = lz_mask[digit_idx];
  assign dp_hi     = dp_en_s[digit_idx];

  seven_seg_decoder u_dec (
    .digit (cur_digit),
    .blank (cur_blank),
    .seg   (seg_hi)
  );

  // Anode select: all off during the ghost-blank window at the head of each slot,
  // so the previous digit's segments never flash on the new anode.
  always_comb begin
    an_hi = '0;
    if (timer >= BLANK_LIM) begin
      an_hi[digit_idx] = 1'b1;
    end
  end

  // Output registers; async reset forces every pad to its inactive level at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= {7{POL}};
      dp  <= POL;
      an  <= {NUM_DIGITS{POL}};
    end else begin
      seg <= seg_hi ^ {7{POL}};
      dp  <= dp_hi ^ POL;
      an  <= an_hi ^ {NUM_DIGITS{POL}};
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with NUM_DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, active-low.
// Output frame f spans the 16 edges after reset release; samples are taken on the falling edge.
// Expected segment patterns are hand-decoded glyphs in active-high form, inverted for comparison.
module tb_bcd_display_scanner;

  logic        clk;
  logic        rst;
  logic [15:0] bcd;
  logic [3:0]  dp_en;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  int tests_run;
  int tests_failed;

  bcd_display_scanner #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (4),
    .BLANK_CYC  (1),
    .ACTIVE_LOW (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd       (bcd),
    .dp_en     (dp_en),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .digit_idx (digit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checks one output frame. s0..s3 are active-high glyphs for digits 0..3,
  // dpm the active-high dp per digit. 'first' skips the seg check of the very
  // first ghost cycle after reset, which still shows the cleared snapshot.
  // If chg_slot matches a slot, bcd is changed to chg_bcd as that slot starts.
  task automatic check_frame(input string tag,
                             input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic [3:0] dpm, input bit first,
                             input int chg_slot, input logic [15:0] chg_bcd);
    logic [6:0] exp_hi [4];
    logic [6:0] exp_seg;
    logic [3:0] onehot;
    logic [3:0] exp_an;
    logic       exp_dp;
    exp_hi[0] = s0;
    exp_hi[1] = s1;
    exp_hi[2] = s2;
    exp_hi[3] = s3;
    for (int j = 0; j < 4; j++) begin
      if (j == chg_slot) bcd = chg_bcd;
      exp_seg = ~exp_hi[j];
      onehot  = 4'b0001 << j;
      exp_an  = ~onehot;
      exp_dp  = ~dpm[j];
      @(negedge clk);
      check($sformatf("%s.d%0d.an_ghost", tag, j), an, 4'hF);
      if (!(first && j == 0))
        check($sformatf("%s.d%0d.seg_ghost", tag, j), seg, exp_seg);
      @(negedge clk);
      check($sformatf("%s.d%0d.an", tag, j), an, exp_an);
      check($sformatf("%s.d%0d.seg", tag, j), seg, exp_seg);
      check($sformatf("%s.d%0d.dp", tag, j), dp, exp_dp);
      check($sformatf("%s.d%0d.idx", tag, j), digit_idx, j);
      @(negedge clk);
      @(negedge clk);
      check($sformatf("%s.d%0d.an_hold", tag, j), an, exp_an);
    end
  endtask

  task automatic skip_frame();
    repeat (16) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst      = 1'b0;
    bcd      = 16'h1234;
    dp_en    = 4'b0000;
    blank_lz = 1'b0;
    #1 rst = 1'b1;

    // Reset state, then held over 10 clocks.
    @(negedge clk);
    check("rst.seg", seg, 7'h7F);
    check("rst.dp", dp, 1'b1);
    check("rst.an", an, 4'hF);
    check("rst.idx", digit_idx, 2'd0);
    repeat (10) @(negedge clk);
    check("rst_hold.seg", seg, 7'h7F);
    check("rst_hold.dp", dp, 1'b1);
    check("rst_hold.an", an, 4'hF);
    check("rst_hold.idx", digit_idx, 2'd0);

    // Plain scan of 1234, and the wrap back into the next frame.
    rst = 1'b0;
    check_frame("scan0", 7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0000, 1'b1, -1, 16'h0);
    check_frame("scan1", 7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0000, 1'b0, -1, 16'h0);

    // Leading-zero blanking.
    bcd = 16'h0050; blank_lz = 1'b1;
    skip_frame();
    check_frame("lz0050", 7'h3F, 7'h6D, 7'h00, 7'h00, 4'b0000, 1'b0, -1, 16'h0);
    bcd = 16'h0000;
    skip_frame();
    check_frame("lz0000", 7'h3F, 7'h00, 7'h00, 7'h00, 4'b0000, 1'b0, -1, 16'h0);
    blank_lz = 1'b0;
    skip_frame();
    check_frame("nolz0000", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000, 1'b0, -1, 16'h0);

    // A blanked leading zero still shows its decimal point.
    bcd = 16'h0005; dp_en = 4'b0100; blank_lz = 1'b1;
    skip_frame();
    check_frame("lzdp", 7'h6D, 7'h00, 7'h00, 7'h00, 4'b0100, 1'b0, -1, 16'h0);

    // Snapshot: change mid-frame at digit 1, visible only from the next frame.
    bcd = 16'h1111; dp_en = 4'b0000; blank_lz = 1'b0;
    skip_frame();
    check_frame("snap_old", 7'h06, 7'h06, 7'h06, 7'h06, 4'b0000, 1'b0, 1, 16'h2222);
    check_frame("snap_new", 7'h5B, 7'h5B, 7'h5B, 7'h5B, 4'b0000, 1'b0, -1, 16'h0);

    // Invalid codes show a dash; dp on digit 2.
    bcd = 16'hA9F0; dp_en = 4'b0100;
    skip_frame();
    check_frame("inval", 7'h3F, 7'h40, 7'h6F, 7'h40, 4'b0100, 1'b0, -1, 16'h0);

    // Async reset while digit 2 is lit.
    repeat (10) @(negedge clk);
    check("midrst.pre_idx", digit_idx, 2'd2);
    check("midrst.pre_an", an, 4'hB);
    #2 rst = 1'b1;
    #1;
    check("midrst.an", an, 4'hF);
    check("midrst.seg", seg, 7'h7F);
    check("midrst.dp", dp, 1'b1);
    check("midrst.idx", digit_idx, 2'd0);
    bcd = 16'h5678; dp_en = 4'b0000; blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_frame("restart", 7'h7F, 7'h07, 7'h7D, 7'h6D, 4'b0000, 1'b1, -1, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
